gpc2311_5_reg: RTL and testbench
================================

Name: gpc2311_5_reg

Overview:
- Registered generalized parallel counter (GPC) of type (2,3,1,1;5): compresses 7 weighted input bits into one 5-bit binary sum.
- Building block for multiplier / multi-operand adder compressor trees.
- Input columns are at weights 1, 2, 4 and 8.
- A valid strobe travels alongside the data; the result is registered so that tree stages align on clock edges.

Parameters:
- IN_REG, default 0: 1 inserts an input register stage, giving latency 2; 0 gives latency 1.

Ports:
- clk        input   1  system clock, rising edge active
- rst        input   1  asynchronous, active-high reset
- in_valid   input   1  src0..src3 carry a valid operand this cycle
- src0       input   1  column 0 bit, weight 1
- src1       input   1  column 1 bit, weight 2
- src2       input   3  column 2 bits, each weight 4
- src3       input   2  column 3 bits, each weight 8
- dst        output  5  registered sum
- out_valid  output  1  dst holds a result

Behaviour:
- Function: dst = src0 + 2*src1 + 4*popcount(src2) + 8*popcount(src3).
  - Range is 0..31 and always fits in 5 bits; there is no overflow or truncation.
  - Inputs are unsigned bit counts.
- Required structure (no carry-propagate adder):
  - FA_A = full adder on src2[2:0], giving sA at weight 4 and cA at weight 8.
  - FA_B = full adder on {src3[1], src3[0], cA}, giving sB at weight 8 and cB at weight 16.
  - dst_next = {cB, sB, sA, src1, src0}.
- Latency:
  - IN_REG=0: the result of inputs sampled at edge N appears on dst at edge N, and out_valid = in_valid from that same sample.
  - IN_REG=1: inputs are registered at edge N, and dst/out_valid update at edge N+1. Total latency is 2 edges.
- Valid handling:
  - out_valid is a pipelined copy of in_valid; there is no backpressure.
  - The dst register loads only when the valid in its stage is 1. Otherwise it holds its previous value (clock-enable, reduces toggling).
  - out_valid always loads, so it deasserts the cycle after the pipeline carries invalid data.
- Reset:
  - On rst=1, asynchronously and immediately: dst=0, out_valid=0, and all internal pipeline registers (data and valid) are cleared.
  - Reset asserted mid-operation discards in-flight data.
  - The first valid result after reset release follows the normal latency.
- Back-to-back: one result per cycle at full throughput. Consecutive valid inputs produce consecutive valid outputs in order.
- Inputs with in_valid=0 never affect dst.

Decomposition:
- Shared package gpc_pkg:
  - constants GPC2311_IN_W = 7 and GPC2311_OUT_W = 5;
  - column weight constants W0=1, W1=2, W2=4, W3=8;
  - packed struct type for the 7 input bits, ordered {src3, src2, src1, src0}.
- One sub-module, gpc_full_adder: 3 inputs → sum and carry, purely combinational. It is instantiated twice (FA_A, FA_B).
- The top level holds the optional input register stage, the output register and the valid pipeline.

Test Plan:
1. Exhaustive sweep, IN_REG=0: drive all 128 values of {src3[1], src3[0], src2[2:0], src1, src0} with in_valid=1, one per cycle.
   - Each dst, one edge later, equals the weighted sum above.
   - Examples: 7'h00→0, 7'h01→1, 7'h02→2, 7'h04→4, 7'h1C→12, 7'h60→16, 7'h7F→31.
2. Carry chain check: src2=3'b111, src3=2'b11, src0=1, src1=1.
   - Result dst=5'b11111 (31); cB=1, sB=1, sA=1.
   - With src2=3'b011 and src3=2'b01: dst=16 (cA propagates into FA_B).
3. Valid gating: valid 7'h7F, then in_valid=0 with inputs 7'h00.
   - dst stays 31 and out_valid drops to 0 on the next edge.
4. Reset mid-stream: assert rst asynchronously between clock edges while dst=31 and out_valid=1.
   - dst=0 and out_valid=0 immediately, without waiting for a clock edge.
   - After release, input 7'h05 (src0=1, src2[0]=1) gives dst=5 at the normal latency.
5. IN_REG=1 latency: a single valid pulse with 7'h0A (src1=1, src2[1]=1).
   - dst=6 and out_valid=1 exactly 2 edges after sampling.
   - Back-to-back inputs 7'h0A then 7'h40 give dst=6 then dst=8 on consecutive cycles.

Source files
------------

// File: rtl/gpc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : gpc_pkg                                                    |
// | Brief   : Shared widths, column weights and input bundle for GPCs.   |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package gpc_pkg;

  localparam int GPC2311_IN_W  = 7;
  localparam int GPC2311_OUT_W = 5;

  localparam int W0 = 1;
  localparam int W1 = 2;
  localparam int W2 = 4;
  localparam int W3 = 8;

  // Packed so that bit 0 is src0 and bits 6:5 are src3.
  typedef struct packed {
    logic [1:0] src3;
    logic [2:0] src2;
    logic       src1;
    logic       src0;
  } gpc2311_in_t;

endpackage
`default_nettype wire

// File: rtl/gpc_full_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : gpc_full_adder                                             |
// | Brief   : Combinational 3:2 counter (sum and carry of three bits).   |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module gpc_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule
`default_nettype wire

// File: rtl/gpc2311_5_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : gpc2311_5_reg                                              |
// | Brief   : Registered (2,3,1,1;5) parallel counter, optional in reg.  |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module gpc2311_5_reg
  import gpc_pkg::*;
#(
  parameter int IN_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     src0,
  input  logic                     src1,
  input  logic [2:0]               src2,
  input  logic [1:0]               src3,
  output logic [GPC2311_OUT_W-1:0] dst,
  output logic                     out_valid
);

  gpc2311_in_t              w_in;
  gpc2311_in_t              w_stage;
  logic                     w_stage_valid;
  logic                     w_sa;
  logic                     w_ca;
  logic                     w_sb;
  logic                     w_cb;
  logic [GPC2311_OUT_W-1:0] w_dst_next;
  logic [GPC2311_OUT_W-1:0] r_dst;
  logic                     r_out_valid;

  assign w_in = '{src3: src3, src2: src2, src1: src1, src0: src0};

  generate
    if (IN_REG != 0) begin : g_in_reg
      gpc2311_in_t r_in;
      logic        r_in_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_in       <= '0;
          r_in_valid <= 1'b0;
        end else begin
          r_in       <= w_in;
          r_in_valid <= in_valid;
        end
      end

      assign w_stage       = r_in;
      assign w_stage_valid = r_in_valid;
    end else begin : g_no_in_reg
      assign w_stage       = w_in;
      assign w_stage_valid = in_valid;
    end
  endgenerate

  // Weight-4 column reduces to sA plus a carry into the weight-8 column.
  gpc_full_adder u_fa_a (
    .a  (w_stage.src2[0]),
    .b  (w_stage.src2[1]),
    .ci (w_stage.src2[2]),
    .s  (w_sa),
    .co (w_ca)
  );

  gpc_full_adder u_fa_b (
    .a  (w_stage.src3[0]),
    .b  (w_stage.src3[1]),
    .ci (w_ca),
    .s  (w_sb),
    .co (w_cb)
  );

  assign w_dst_next = {w_cb, w_sb, w_sa, w_stage.src1, w_stage.src0};

  // Data register is clock-enabled by valid; the valid flag always loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dst       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_stage_valid) begin
        r_dst <= w_dst_next;
      end
      r_out_valid <= w_stage_valid;
    end
  end

  assign dst       = r_dst;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_gpc2311_5_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_gpc2311_5_reg                                           |
// | Brief   : Directed vector bench for both IN_REG settings.            |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_gpc2311_5_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       src0 = 1'b0;
  logic       src1 = 1'b0;
  logic [2:0] src2 = '0;
  logic [1:0] src3 = '0;
  logic [4:0] dst0, dst1;
  logic       ov0, ov1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [6:0] bits;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  gpc2311_5_reg #(.IN_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .src0(src0), .src1(src1),
    .src2(src2), .src3(src3), .dst(dst0), .out_valid(ov0)
  );

  gpc2311_5_reg #(.IN_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .src0(src0), .src1(src1),
    .src2(src2), .src3(src3), .dst(dst1), .out_valid(ov1)
  );

  function automatic logic [4:0] model(input logic [6:0] b);
    int sum;
    sum = int'(b[0]) + 2 * int'(b[1]) + 4 * $countones(b[4:2]) + 8 * $countones(b[6:5]);
    return sum[4:0];
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] b, input logic v);
    {src3, src2, src1, src0} = b;
    in_valid = v;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Hand-computed examples first, then the full 128-value sweep.
    tbl.push_back('{7'h00, 5'd0});
    tbl.push_back('{7'h01, 5'd1});
    tbl.push_back('{7'h02, 5'd2});
    tbl.push_back('{7'h04, 5'd4});
    tbl.push_back('{7'h1C, 5'd12});
    tbl.push_back('{7'h60, 5'd16});
    tbl.push_back('{7'h7F, 5'd31});
    tbl.push_back('{7'h2C, 5'd16});
    tbl.push_back('{7'h0A, 5'd6});
    tbl.push_back('{7'h40, 5'd8});
    for (int i = 0; i < 128; i++) begin
      logic [6:0] b;
      b = 7'(i);
      tbl.push_back('{b, model(b)});
    end

    #2;
    chk("reset_dst0", dst0, 5'd0);
    chk("reset_ov0", {4'd0, ov0}, 5'd0);
    chk("reset_dst1", dst1, 5'd0);
    chk("reset_ov1", {4'd0, ov1}, 5'd0);
    @(negedge clk);
    rst = 1'b0;

    // IN_REG=0 result appears one edge later; IN_REG=1 trails by one more.
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].bits, 1'b1);
      step();
      chk($sformatf("sweep0_%02h", tbl[k].bits), dst0, tbl[k].exp);
      chk("sweep0_ov", {4'd0, ov0}, 5'd1);
      if (k > 0) begin
        chk($sformatf("sweep1_%02h", tbl[k-1].bits), dst1, tbl[k-1].exp);
        chk("sweep1_ov", {4'd0, ov1}, 5'd1);
      end else begin
        chk("sweep1_first_ov", {4'd0, ov1}, 5'd0);
      end
    end

    // Valid gating: invalid zeros must not overwrite the held 31.
    drive(7'h7F, 1'b1);
    step();
    chk("gate_dst0_load", dst0, 5'd31);
    drive(7'h00, 1'b0);
    step();
    chk("gate_dst0_hold", dst0, 5'd31);
    chk("gate_ov0_drop", {4'd0, ov0}, 5'd0);
    chk("gate_dst1_load", dst1, 5'd31);
    chk("gate_ov1_still", {4'd0, ov1}, 5'd1);
    step();
    chk("gate_dst1_hold", dst1, 5'd31);
    chk("gate_ov1_drop", {4'd0, ov1}, 5'd0);
    chk("gate_dst0_hold2", dst0, 5'd31);

    // Asynchronous reset mid-cycle with 31 in flight.
    drive(7'h7F, 1'b1);
    step();
    chk("prerst_ov0", {4'd0, ov0}, 5'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_dst0", dst0, 5'd0);
    chk("async_rst_ov0", {4'd0, ov0}, 5'd0);
    chk("async_rst_dst1", dst1, 5'd0);
    chk("async_rst_ov1", {4'd0, ov1}, 5'd0);
    @(negedge clk);
    drive(7'h05, 1'b1);
    rst = 1'b0;
    step();
    chk("postrst_dst0", dst0, 5'd5);
    chk("postrst_ov0", {4'd0, ov0}, 5'd1);
    chk("postrst_dst1_flushed", dst1, 5'd0);
    chk("postrst_ov1", {4'd0, ov1}, 5'd0);
    drive(7'h00, 1'b0);
    step();
    chk("postrst_dst1", dst1, 5'd5);
    chk("postrst_ov1_late", {4'd0, ov1}, 5'd1);
    step();

    // IN_REG=1 single pulse: result exactly two edges after sampling.
    drive(7'h0A, 1'b1);
    step();
    drive(7'h00, 1'b0);
    chk("pulse1_edge1_ov", {4'd0, ov1}, 5'd0);
    chk("pulse1_edge1_dst", dst1, 5'd5);
    step();
    chk("pulse1_edge2_dst", dst1, 5'd6);
    chk("pulse1_edge2_ov", {4'd0, ov1}, 5'd1);
    step();
    chk("pulse1_edge3_ov", {4'd0, ov1}, 5'd0);

    // Back-to-back through the registered input stage.
    drive(7'h0A, 1'b1);
    step();
    drive(7'h40, 1'b1);
    step();
    drive(7'h00, 1'b0);
    chk("b2b_first", dst1, 5'd6);
    chk("b2b_first_ov", {4'd0, ov1}, 5'd1);
    step();
    chk("b2b_second", dst1, 5'd8);
    chk("b2b_second_ov", {4'd0, ov1}, 5'd1);
    step();
    chk("b2b_hold", dst1, 5'd8);
    chk("b2b_ov_drop", {4'd0, ov1}, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
